// File: rtl/btn_repeat_pkg.sv
// Shared definitions for the push-button conditioning bank: channel state
// encoding and the counter width derivation.
package btn_repeat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_HELD_DELAY  = 3'd2,
        ST_HELD_REPEAT = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } btn_state_e;

    // One extra bit above the largest limit so cnt never wraps before it fires.
    function automatic int cnt_width(input int deb, input int dly, input int rate);
        int m;
        m = deb;
        if (dly > m) m = dly;
        if (rate > m) m = rate;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/btn_repeat_channel.sv
// One button channel: 2-flop synchroniser, debounce/auto-repeat FSM and counter.
// Optional release pulse output when BTN_RELEASE_PULSE_EN is defined.
module btn_repeat_channel
    import btn_repeat_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int REPEAT_DELAY = 10,
    parameter int REPEAT_RATE  = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       rpt_en,
    input  logic       pb,
    output logic       dpb,
    output logic       scen,
    output logic       rpt,
`ifdef BTN_RELEASE_PULSE_EN
    output logic       rel,
`endif
    output logic [2:0] state_dbg
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    logic             s1, s2;
    btn_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dpb_nxt, scen_nxt, rpt_nxt;
`ifdef BTN_RELEASE_PULSE_EN
    logic             rel_nxt;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ST_IDLE;
            cnt   <= '0;
            dpb   <= 1'b0;
            scen  <= 1'b0;
            rpt   <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            rel   <= 1'b0;
`endif
        end else begin
            s1    <= pb;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dpb   <= dpb_nxt;
            scen  <= scen_nxt;
            rpt   <= rpt_nxt;
`ifdef BTN_RELEASE_PULSE_EN
            rel   <= rel_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        dpb_nxt   = dpb;
        scen_nxt  = 1'b0;
        rpt_nxt   = 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
        rel_nxt   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (s2) state_nxt = ST_DEB_PRESS;
            end
            ST_DEB_PRESS: begin
                if (!s2) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = ST_HELD_DELAY;
                    cnt_nxt   = '0;
                    dpb_nxt   = 1'b1;
                    scen_nxt  = 1'b1;
                    rpt_nxt   = 1'b1;
                end
            end
            ST_HELD_DELAY: begin
                if (!s2) begin
                    state_nxt = ST_DEB_RELEASE;
                    cnt_nxt   = '0;
                end else if (cnt == DLY_LAST) begin
                    // A masked channel parks here with the counter pinned.
                    if (rpt_en) begin
                        state_nxt = ST_HELD_REPEAT;
                        cnt_nxt   = '0;
                        rpt_nxt   = 1'b1;
                    end else begin
                        cnt_nxt   = cnt;
                    end
                end
            end
            ST_HELD_REPEAT: begin
                if (!s2) begin
                    state_nxt = ST_DEB_RELEASE;
                    cnt_nxt   = '0;
                end else if (cnt == RATE_LAST) begin
                    cnt_nxt = '0;
                    rpt_nxt = 1'b1;
                end
            end
            ST_DEB_RELEASE: begin
                if (s2) begin
                    state_nxt = ST_HELD_DELAY;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    dpb_nxt   = 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
                    rel_nxt   = 1'b1;
`endif
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign state_dbg = state;

endmodule

// File: rtl/btn_repeat_bank.sv
// Bank of N_CH independent button channels (debounce, press pulse, auto-repeat).
// Define BTN_RELEASE_PULSE_EN to add the REL release-pulse output.
module btn_repeat_bank
    import btn_repeat_pkg::*;
#(
    parameter int              N_CH         = 5,
    parameter int              DEBOUNCE_CYC = 4,
    parameter int              REPEAT_DELAY = 10,
    parameter int              REPEAT_RATE  = 3,
    parameter logic [N_CH-1:0] RPT_MASK     = {N_CH{1'b1}}
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [N_CH-1:0]     PB,
    output logic [N_CH-1:0]     DPB,
    output logic [N_CH-1:0]     SCEN,
    output logic [N_CH-1:0]     RPT,
`ifdef BTN_RELEASE_PULSE_EN
    output logic [N_CH-1:0]     REL,
`endif
    output logic [3*N_CH-1:0]   state_dbg
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_repeat_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .Clk       (Clk),
            .Reset     (Reset),
            .rpt_en    (RPT_MASK[i]),
            .pb        (PB[i]),
            .dpb       (DPB[i]),
            .scen      (SCEN[i]),
            .rpt       (RPT[i]),
`ifdef BTN_RELEASE_PULSE_EN
            .rel       (REL[i]),
`endif
            .state_dbg (state_dbg[3*i +: 3])
        );
    end

endmodule

// File: tb/tb_btn_repeat_bank.sv
// Bench for btn_repeat_bank: directed button scenarios then random presses,
// two instances (all channels repeating / channel 0 repeat-masked).
module tb_btn_repeat_bank;

    localparam int N    = 5;
    localparam int DEB  = 4;
    localparam int DLY  = 10;
    localparam int RATE = 3;
    localparam int W    = 4 * N;
    localparam logic [N-1:0] MASK_A = 5'b11111;
    localparam logic [N-1:0] MASK_B = 5'b11110;

    logic         clk = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] PB = '0;
    logic [N-1:0] dpb_a, scen_a, rpt_a, rel_a;
    logic [N-1:0] dpb_b, scen_b, rpt_b, rel_b;
    logic [3*N-1:0] dbg_a, dbg_b;

    btn_repeat_bank #(.N_CH(N), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(DLY),
                      .REPEAT_RATE(RATE), .RPT_MASK(MASK_A)) dut_a (
        .Clk(clk), .Reset(Reset), .PB(PB), .DPB(dpb_a), .SCEN(scen_a), .RPT(rpt_a),
`ifdef BTN_RELEASE_PULSE_EN
        .REL(rel_a),
`endif
        .state_dbg(dbg_a)
    );

    btn_repeat_bank #(.N_CH(N), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(DLY),
                      .REPEAT_RATE(RATE), .RPT_MASK(MASK_B)) dut_b (
        .Clk(clk), .Reset(Reset), .PB(PB), .DPB(dpb_b), .SCEN(scen_b), .RPT(rpt_b),
`ifdef BTN_RELEASE_PULSE_EN
        .REL(rel_b),
`endif
        .state_dbg(dbg_b)
    );

`ifndef BTN_RELEASE_PULSE_EN
    assign rel_a = '0;
    assign rel_b = '0;
`endif

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: per channel, debounced level plus run/hold timers.
    bit m_s1 [2][N];
    bit m_s2 [2][N];
    bit m_dl [2][N];
    int m_run[2][N];
    int m_ht [2][N];
    bit m_scen[2][N];
    bit m_rpt [2][N];
    bit m_rel [2][N];

    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    logic [N-1:0] prev_scen_a = '0, prev_rpt_a = '0;

    task automatic model_edge(input logic [N-1:0] pb, input logic rst);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                bit x;
                bit msk;
                msk = (d == 0) ? MASK_A[c] : MASK_B[c];
                m_scen[d][c] = 1'b0;
                m_rpt[d][c]  = 1'b0;
                m_rel[d][c]  = 1'b0;
                if (rst) begin
                    m_s1[d][c] = 1'b0; m_s2[d][c] = 1'b0; m_dl[d][c] = 1'b0;
                    m_run[d][c] = 0;   m_ht[d][c] = 0;
                end else begin
                    x = m_s2[d][c];
                    m_s2[d][c] = m_s1[d][c];
                    m_s1[d][c] = pb[c];
                    if (!m_dl[d][c]) begin
                        // Needs DEB+1 consecutive high samples to accept a press.
                        if (x) begin
                            m_run[d][c]++;
                            if (m_run[d][c] == DEB + 1) begin
                                m_dl[d][c] = 1'b1; m_run[d][c] = 0; m_ht[d][c] = 0;
                                m_scen[d][c] = 1'b1; m_rpt[d][c] = 1'b1;
                            end
                        end else begin
                            m_run[d][c] = 0;
                        end
                    end else begin
                        if (!x) begin
                            m_run[d][c]++;
                            if (m_run[d][c] == DEB + 1) begin
                                m_dl[d][c] = 1'b0; m_run[d][c] = 0; m_rel[d][c] = 1'b1;
                            end
                        end else if (m_run[d][c] > 0) begin
                            m_run[d][c] = 0; m_ht[d][c] = 0;
                        end else begin
                            m_ht[d][c]++;
                            if (msk && m_ht[d][c] >= DLY && (m_ht[d][c] - DLY) % RATE == 0)
                                m_rpt[d][c] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [W-1:0] model_vec(input int d);
        logic [N-1:0] v_dpb, v_scen, v_rpt, v_rel;
        for (int c = 0; c < N; c++) begin
            v_dpb[c]  = m_dl[d][c];
            v_scen[c] = m_scen[d][c];
            v_rpt[c]  = m_rpt[d][c];
`ifdef BTN_RELEASE_PULSE_EN
            v_rel[c]  = m_rel[d][c];
`else
            v_rel[c]  = 1'b0;
`endif
        end
        return {v_dpb, v_scen, v_rpt, v_rel};
    endfunction

    // Scoreboard
    task automatic check_field(input string tag, input int d,
                               input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%b expected=%b", tag, d, act, exp);
        end
    endtask

    task automatic check_outputs(input logic was_reset);
        logic [W-1:0] e;
        for (int d = 0; d < 2; d++) begin
            e = exp_q.pop_front();
            check_field("dpb",  d, (d == 0) ? dpb_a  : dpb_b,  e[4*N-1:3*N]);
            check_field("scen", d, (d == 0) ? scen_a : scen_b, e[3*N-1:2*N]);
            check_field("rpt",  d, (d == 0) ? rpt_a  : rpt_b,  e[2*N-1:N]);
            check_field("rel",  d, (d == 0) ? rel_a  : rel_b,  e[N-1:0]);
        end
        if (was_reset) begin
            n_cmp++;
            assert ({dbg_a, dbg_b} === '0) else begin
                n_fail++;
                $error("FAIL reset_state observed=%h expected=0", {dbg_a, dbg_b});
            end
        end
        n_cmp++;
        assert (((scen_a & prev_scen_a) | (rpt_a & prev_rpt_a)) === '0) else begin
            n_fail++;
            $error("FAIL pulse_width observed scen=%b rpt=%b after scen=%b rpt=%b required no overlap",
                   scen_a, rpt_a, prev_scen_a, prev_rpt_a);
        end
        prev_scen_a = scen_a;
        prev_rpt_a  = rpt_a;
    endtask

    // Drivers
    task automatic step(input logic [N-1:0] pb, input logic rst);
        @(negedge clk);
        PB    = pb;
        Reset = rst;
        @(posedge clk);
        model_edge(pb, rst);
        exp_q.push_back(model_vec(0));
        exp_q.push_back(model_vec(1));
        #1;
        check_outputs(rst);
    endtask

    task automatic hold(input logic [N-1:0] pb, input int n);
        for (int i = 0; i < n; i++) step(pb, 1'b0);
    endtask

    initial begin
        logic [N-1:0] pb_r;
        logic rst_r;

        step('0, 1'b1);
        step('0, 1'b1);
        hold('0, 3);

        // Clean press ch0, then release glitch and clean release
        hold(5'b00001, 40);
        hold('0, 2);
        hold(5'b00001, 15);
        hold('0, 12);

        // Bounce on ch1
        hold(5'b00010, 2);
        hold('0, 1);
        hold(5'b00010, 15);
        hold('0, 12);

        // Simultaneous press on ch2 and ch3
        hold(5'b01100, 20);
        hold('0, 12);

        // Reset in the middle of a held press
        hold(5'b00001, 14);
        step(5'b00001, 1'b1);
        hold(5'b00001, 12);
        hold('0, 12);

        // Random presses with long holds and occasional resets
        pb_r = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 11) == 0) pb_r[c] = ~pb_r[c];
            rst_r = ($urandom_range(0, 399) == 0);
            step(pb_r, rst_r);
        end
        hold('0, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
